bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2: number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = modulo wrap at the boundaries, 0 = saturate at the boundaries.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel-load request.
REQ-008 The block SHALL have port load_val, input, 4*DIGITS bits: BCD value to load, digit 0 in bits [3:0].
REQ-009 The block SHALL have port count, output, 4*DIGITS bits: current BCD count, digit 0 in bits [3:0].
REQ-010 The block SHALL have port tc, output, 1 bit: registered one-cycle boundary pulse (carry or borrow).
REQ-011 The block SHALL have port load_err, output, 1 bit: registered one-cycle pulse on a rejected load.

Function
REQ-012 Per-edge priority SHALL be: load first, then en, then hold.
REQ-013 Load, all nibbles of load_val <= 9: count <= load_val on the next edge; tc = 0; load_err = 0.
REQ-014 Load, any nibble of load_val > 9: count SHALL hold, load_err = 1 for exactly one cycle, and en SHALL be ignored that cycle.
REQ-015 Increment: digit 0 SHALL go +1; a digit at 9 SHALL become 0 and carry into the next digit; all ripple SHALL complete in the same cycle.
REQ-016 Decrement: digit 0 SHALL go -1; a digit at 0 SHALL become 9 and borrow from the next digit; all ripple SHALL complete in the same cycle.
REQ-017 Every count nibble SHALL always hold a value in 0..9; a non-BCD value SHALL never be reachable.
REQ-018 Upper boundary, WRAP=1: increment from all-9s (MAX = 10^DIGITS - 1) SHALL give count = 0 and tc = 1 for one cycle.
REQ-019 Lower boundary, WRAP=1: decrement from 0 SHALL give count = MAX and tc = 1 for one cycle.
REQ-020 Boundaries, WRAP=0: increment at MAX and decrement at 0 SHALL hold count and assert tc for every cycle in which such a step is requested.
REQ-021 tc SHALL be 0 for every step that does not cross a boundary, and whenever en = 0 with no load.
REQ-022 Changing up between cycles SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-023 Latency from input to count, tc or load_err SHALL be one clock edge; all outputs SHALL be registered.

Reset
REQ-024 While reset = 0, count, tc and load_err SHALL be 0 immediately, independent of clk.
REQ-025 Reset asserted mid-count or mid-load SHALL abort the operation, with no partial update after release.
REQ-026 After reset deasserts, the first state change SHALL occur on the first rising clk edge that sees reset = 1.

Verification
REQ-027 Scenario 1, DIGITS=2, WRAP=1: reset, then en=1, up=1 for 100 cycles -> count runs 00..99, reaches 0x00 on edge 100, tc pulses once.
REQ-028 Scenario 2: load 0x00, then en=1, up=0 -> count = 0x99 with tc = 1, next edge 0x98 with tc = 0.
REQ-029 Scenario 3: load=1 with load_val=0x3A while en=1 -> count holds, load_err = 1 for one cycle; then load 0x47 -> count = 0x47, load_err = 0.
REQ-030 Scenario 4, WRAP=0: load 0x98, then up for 3 cycles -> count 0x99, 0x99, 0x99 and tc = 0, 1, 1.
REQ-031 Scenario 5, DIGITS=4: load 0x0999, then one increment -> count = 0x1000 with tc = 0.
REQ-032 Scenario 6: reset pulled low between clock edges at count 0x57 -> count = 0x00 before the next edge; the count then resumes from 0x01 after release.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap or saturate boundaries.
// Outputs are registered: count, boundary pulse tc, and rejected-load pulse load_err.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_tc;
  logic         r_load_err;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_inc_c;
  logic         w_dec_b;
  logic         w_load_ok;
  logic [W-1:0] w_next_count;
  logic         w_next_tc;
  logic         w_next_err;

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  assign w_load_ok = is_bcd(load_val);

  // Increment ripple; w_inc_c ends up set only when every digit was 9.
  always_comb begin
    w_inc   = r_count;
    w_inc_c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_inc_c) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_inc_c         = 1'b0;
        end
      end else begin
        w_inc[4*i +: 4] = r_count[4*i +: 4];
      end
    end
  end

  // Decrement ripple; w_dec_b ends up set only when every digit was 0.
  always_comb begin
    w_dec   = r_count;
    w_dec_b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_dec_b) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_dec_b         = 1'b0;
        end
      end else begin
        w_dec[4*i +: 4] = r_count[4*i +: 4];
      end
    end
  end

  // Next state: load beats enable; a rejected load also suppresses counting.
  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    w_next_err   = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_next_count = load_val;
      end else begin
        w_next_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        w_next_tc    = w_inc_c;
        w_next_count = (w_inc_c && (WRAP == 0)) ? r_count : w_inc;
      end else begin
        w_next_tc    = w_dec_b;
        w_next_count = (w_dec_b && (WRAP == 0)) ? r_count : w_dec;
      end
    end else begin
      w_next_count = r_count;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_tc       <= w_next_tc;
      r_load_err <= w_next_err;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: three counter variants (2-digit wrap, 2-digit saturate, 4-digit wrap)
// share control inputs; an integer model pushes expectations that are popped after each edge.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  lv2 = 8'h00;
  logic [15:0] lv4 = 16'h0000;

  logic [7:0]  c2, c2s;
  logic [15:0] c4;
  logic        tc2, tc2s, tc4;
  logic        e2, e2s, e4;

  typedef struct packed {
    logic [15:0] cnt;
    logic        tc;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q2s[$];
  exp_t q4[$];

  int m2 = 0, m2s = 0, m4 = 0;
  int n_checks = 0;
  int n_errors = 0;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_wrap2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv2), .count(c2), .tc(tc2), .load_err(e2));

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_sat2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv2), .count(c2s), .tc(tc2s), .load_err(e2s));

  bcd_updown_counter #(.DIGITS(4), .WRAP(1)) u_wrap4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv4), .count(c4), .tc(tc4), .load_err(e4));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = 16'h0000;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic is_valid(input logic [15:0] v, input int d);
    logic ok = 1'b1;
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic exp_t model_step(input int m_in, input int d, input int wrap,
                                      input logic [15:0] lv, output int m_out);
    exp_t e;
    int mx = 10 ** d - 1;
    e.tc = 1'b0;
    e.err = 1'b0;
    m_out = m_in;
    if (load) begin
      if (is_valid(lv, d)) m_out = bcd2int(lv, d);
      else e.err = 1'b1;
    end else if (en) begin
      if (up) begin
        if (m_in == mx) begin
          e.tc = 1'b1;
          m_out = (wrap != 0) ? 0 : mx;
        end else m_out = m_in + 1;
      end else begin
        if (m_in == 0) begin
          e.tc = 1'b1;
          m_out = (wrap != 0) ? mx : 0;
        end else m_out = m_in - 1;
      end
    end
    e.cnt = int2bcd(m_out);
    return e;
  endfunction

  task automatic step(input logic l, input logic e_i, input logic u, input logic [7:0] v2,
                      input logic [15:0] v4, input string tag);
    exp_t x;
    int nm;
    load = l; en = e_i; up = u; lv2 = v2; lv4 = v4;
    q2.push_back(model_step(m2, 2, 1, {8'h00, v2}, nm));   m2 = nm;
    q2s.push_back(model_step(m2s, 2, 0, {8'h00, v2}, nm)); m2s = nm;
    q4.push_back(model_step(m4, 4, 1, v4, nm));            m4 = nm;
    @(posedge clk);
    #1;
    x = q2.pop_front();
    check_val({tag, "_w2_cnt"}, 32'(c2), 32'(x.cnt[7:0]));
    check_val({tag, "_w2_tc"}, 32'(tc2), 32'(x.tc));
    check_val({tag, "_w2_err"}, 32'(e2), 32'(x.err));
    x = q2s.pop_front();
    check_val({tag, "_s2_cnt"}, 32'(c2s), 32'(x.cnt[7:0]));
    check_val({tag, "_s2_tc"}, 32'(tc2s), 32'(x.tc));
    check_val({tag, "_s2_err"}, 32'(e2s), 32'(x.err));
    x = q4.pop_front();
    check_val({tag, "_w4_cnt"}, 32'(c4), 32'(x.cnt));
    check_val({tag, "_w4_tc"}, 32'(tc4), 32'(x.tc));
    check_val({tag, "_w4_err"}, 32'(e4), 32'(x.err));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_w2"}, {22'd0, tc2, e2, c2}, 32'd0);
    check_val({tag, "_s2"}, {22'd0, tc2s, e2s, c2s}, 32'd0);
    check_val({tag, "_w4"}, {14'd0, tc4, e4, c4}, 32'd0);
  endtask

  initial begin
    logic [15:0] rv;
    #3;
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    reset = 1'b1;

    // Full up-count through the 2-digit wrap point.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "s1_up");
    check_val("s1_final", 32'(c2), 32'h00);

    step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "s2_load0");
    step(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, "s2_dn1");
    step(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, "s2_dn2");

    step(1'b1, 1'b1, 1'b1, 8'h3A, 16'h003A, "s3_bad");
    step(1'b1, 1'b1, 1'b1, 8'h47, 16'h0047, "s3_good");
    step(1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, "hold");

    step(1'b1, 1'b0, 1'b1, 8'h98, 16'h0098, "s4_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "s4_up");

    step(1'b1, 1'b0, 1'b1, 8'h12, 16'h0999, "s5_load");
    step(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "s5_up");
    check_val("s5_wide", 32'(c4), 32'h1000);

    // Direction toggling every cycle.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'(i % 2), 8'h00, 16'h0000, "toggle");

    step(1'b1, 1'b0, 1'b1, 8'h57, 16'h0057, "s6_load");
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("s6_rst");
    m2 = 0; m2s = 0; m4 = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "s6_resume");
    check_val("s6_resume_val", 32'(c2), 32'h01);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) rv = int2bcd(int'($urandom_range(0, 9999)));
      else rv = 16'($urandom);
      step(($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), rv[7:0], rv, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
